// File: rtl/multiword_div_by_word_if.sv
// Handshake bundle for the multi-word by single-word long divider.
// The master modport is the operand/result side; the slave modport is the divider.
interface multiword_div_by_word_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [DATA_WIDTH-1:0] divisor;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] remainder;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        output start, divisor, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, remainder, busy, done, err
    );

    modport slave (
        input  start, divisor, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, remainder, busy, done, err
    );
endinterface

// File: rtl/multiword_div_by_word.sv
// Sequential long divider: NUM_WORDS-word dividend (MSW first) / one-word divisor, one quotient bit per cycle.
// Optional macro DIVZERO_CHECK_EN: a zero divisor ends the operation at once with err set.
module multiword_div_by_word #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    multiword_div_by_word_if.slave  bus
);

    localparam int WCW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int BCW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CALC,
        S_OUT,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] d_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] r_q;
    logic [DATA_WIDTH-1:0] q_q;
    logic [DATA_WIDTH-1:0] rem_q;
    logic [WCW-1:0]        word_cnt;
    logic [BCW-1:0]        bit_cnt;

    logic [DATA_WIDTH:0]   t;
    logic [DATA_WIDTH-1:0] diff;
    logic                  ge;
    logic                  last_bit;
    logic                  last_word;

    // Shift window: running remainder with the next dividend bit appended.
    always_comb begin
        t         = {r_q, a_q[DATA_WIDTH-1]};
        ge        = (t >= {1'b0, d_q});
        diff      = t[DATA_WIDTH-1:0] - d_q;
        last_bit  = (bit_cnt == BCW'(DATA_WIDTH - 1));
        last_word = (word_cnt == WCW'(NUM_WORDS - 1));
    end

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (bus.start) begin
`ifdef DIVZERO_CHECK_EN
                    state_nxt = (bus.divisor == '0) ? S_DONE : S_LOAD;
`else
                    state_nxt = S_LOAD;
`endif
                end
            end
            S_LOAD: if (bus.in_valid)  state_nxt = S_CALC;
            S_CALC: if (last_bit)      state_nxt = S_OUT;
            S_OUT:  if (bus.out_ready) state_nxt = last_word ? S_DONE : S_LOAD;
            S_DONE:                    state_nxt = S_IDLE;
            default:                   state_nxt = S_IDLE;
        endcase
    end

    // NOTE: every datapath register is reset, since out_data and remainder are
    // visible ports that must read zero after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_q      <= '0;
            a_q      <= '0;
            r_q      <= '0;
            q_q      <= '0;
            rem_q    <= '0;
            word_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        d_q      <= bus.divisor;
                        r_q      <= '0;
                        rem_q    <= '0;
                        word_cnt <= '0;
                    end
                end
                S_LOAD: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.in_data;
                        bit_cnt <= '0;
                    end
                end
                S_CALC: begin
                    // A zero divisor always "fits", so r tracks the low bits of the window.
                    r_q     <= ge ? diff : t[DATA_WIDTH-1:0];
                    q_q     <= DATA_WIDTH'({q_q, ge});
                    a_q     <= a_q << 1;
                    bit_cnt <= bit_cnt + BCW'(1);
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        word_cnt <= word_cnt + WCW'(1);
                        if (last_word) rem_q <= r_q;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DIVZERO_CHECK_EN
    logic err_q;

    // Sticky until the next accepted start re-evaluates the divisor.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                           err_q <= 1'b0;
        else if (state == S_IDLE && bus.start) err_q <= (bus.divisor == '0);
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.in_ready  = (state == S_LOAD);
    assign bus.out_valid = (state == S_OUT);
    assign bus.out_data  = q_q;
    assign bus.remainder = rem_q;
    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = (state == S_DONE);

endmodule

// File: tb/tb_multiword_div_by_word.sv
// Scoreboard bench for multiword_div_by_word (DATA_WIDTH=8, NUM_WORDS=2): driver pushes
// expectations from a big-integer reference, an independent monitor pops and compares.
module tb_multiword_div_by_word;

    localparam int DW       = 8;
    localparam int NW       = 2;
    localparam int AW       = DW * NW;
    localparam int WAIT_MAX = 2000;

    typedef struct {
        logic [DW-1:0] rem;
        logic          err;
        bit            chk_cyc;
        int            start_cyc;
    } done_exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int cyc           = 0;
    int n_cmp         = 0;
    int n_bad         = 0;
    int ops_done      = 0;
    int rdy_mode      = 0;
    int in_ready_seen = 0;

    logic [DW-1:0] q_exp[$];
    done_exp_t     d_exp[$];

    multiword_div_by_word_if #(.DATA_WIDTH(DW)) bus();

    multiword_div_by_word #(.DATA_WIDTH(DW), .NUM_WORDS(NW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_line(input string name, input logic [63:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got %0h expected nothing (t=%0t)", name, act, $time);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_in_ready"},  bus.in_ready,  0);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_busy"},      bus.busy,      0);
        check({tag, "_done"},      bus.done,      0);
        check({tag, "_err"},       bus.err,       0);
        check({tag, "_out_data"},  bus.out_data,  0);
        check({tag, "_remainder"}, bus.remainder, 0);
    endtask

    // Reference: whole-number division of the concatenated dividend.
    task automatic push_expect(input logic [DW-1:0] d, input logic [AW-1:0] a,
                               output bit dz, output logic [DW-1:0] r);
        logic [AW-1:0] q;
        dz = 1'b0;
`ifdef DIVZERO_CHECK_EN
        dz = (d == '0);
`endif
        if (dz) begin
            q = '0;
            r = '0;
        end else if (d == '0) begin
            q = '1;
            r = a[DW-1:0];
        end else begin
            q = a / AW'(d);
            r = DW'(a % AW'(d));
        end
        if (!dz)
            for (int i = NW - 1; i >= 0; i--) q_exp.push_back(q[i*DW +: DW]);
    endtask

    task automatic start_op(input logic [DW-1:0] d, input bit dz, input logic [DW-1:0] r,
                            input bit chk_cyc);
        done_exp_t e;
        bus.start   = 1'b1;
        bus.divisor = d;
        @(posedge clk); #1;
        bus.start   = 1'b0;
        bus.divisor = DW'($urandom);
        e.rem       = r;
        e.err       = dz;
        e.chk_cyc   = chk_cyc;
        e.start_cyc = cyc;
        d_exp.push_back(e);
        check("busy_after_start", bus.busy, 1);
    endtask

    task automatic feed(input logic [DW-1:0] w, output bit ok);
        ok           = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        for (int i = 0; i < WAIT_MAX; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.in_data  = DW'($urandom);
    endtask

    task automatic run_op(input logic [DW-1:0] d, input logic [AW-1:0] a, input bit gaps,
                          input int mode, input bit chk_cyc, input bit poke);
        bit            dz;
        bit            ok;
        logic [DW-1:0] r;
        int            target;
        rdy_mode = mode;
        push_expect(d, a, dz, r);
        target = ops_done + 1;
        start_op(d, dz, r, chk_cyc);
        if (!dz) begin
            for (int i = 0; i < NW; i++) begin
                if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                feed(a[(NW-1-i)*DW +: DW], ok);
                check("in_accepted", ok, 1);
                if (poke && i == 0) begin
                    bus.start   = 1'b1;
                    bus.divisor = ~d;
                    @(posedge clk); #1;
                    bus.start   = 1'b0;
                end
            end
        end
        for (int i = 0; i < WAIT_MAX && ops_done < target; i++) begin @(posedge clk); #1; end
        check("op_done", ops_done >= target, 1);
    endtask

    // Output ready generator: 0 = always ready, 1 = random, 2 = five-cycle stall per word.
    initial begin
        int stall;
        stall         = 0;
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: bus.out_ready = 1'b1;
                1: bus.out_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (!bus.out_valid) begin
                        stall         = 0;
                        bus.out_ready = 1'b0;
                    end else if (stall < 5) begin
                        stall++;
                        bus.out_ready = 1'b0;
                    end else begin
                        bus.out_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    // Monitor: compares everything the DUT presents against the queued expectations.
    initial begin
        logic [DW-1:0] held;
        bit            pend;
        done_exp_t     e;
        pend = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pend = 1'b0;
            end else begin
                if (bus.in_ready) in_ready_seen++;
                if (bus.out_valid) check("ready_valid_excl", bus.in_ready, 0);
                if (pend && bus.out_valid) check("out_hold", bus.out_data, held);
                if (bus.out_valid && bus.out_ready) begin
                    pend = 1'b0;
                    if (q_exp.size() == 0) fail_line("q_unexpected", bus.out_data);
                    else                   check("q_word", bus.out_data, q_exp.pop_front());
                end else begin
                    pend = bus.out_valid;
                    held = bus.out_data;
                end
                if (bus.done) begin
                    if (d_exp.size() == 0) begin
                        fail_line("done_unexpected", bus.remainder);
                    end else begin
                        e = d_exp.pop_front();
                        check("remainder", bus.remainder, e.rem);
                        check("err", bus.err, e.err);
                        check("busy_in_done", bus.busy, 1);
                        if (e.chk_cyc) check("cycles", cyc - e.start_cyc, NW * (DW + 2));
                        ops_done++;
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit            dz;
        bit            ok;
        logic [DW-1:0] r;
        int            seen;
        logic [DW-1:0] rd;
        logic [AW-1:0] ra;
        bit            rg;
        int            rm;

        bus.start    = 1'b0;
        bus.divisor  = '0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        reset        = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("in_reset");
        reset = 1'b0;
        @(posedge clk); #1;
        check_zero_outputs("after_reset");

        // Directed cases.
        run_op(8'h10, 16'h1234, 1'b0, 0, 1'b1, 1'b0);
        run_op(8'h01, 16'hFFFF, 1'b0, 0, 1'b1, 1'b0);
        run_op(8'hFF, 16'hFFFF, 1'b0, 2, 1'b0, 1'b0);
        run_op(8'h37, 16'hBEEF, 1'b0, 0, 1'b1, 1'b1);

        // Zero divisor: early error exit or all-ones quotient depending on build.
        seen = in_ready_seen;
        run_op(8'h00, 16'h1234, 1'b0, 0, 1'b0, 1'b0);
`ifdef DIVZERO_CHECK_EN
        check("divzero_no_in_ready", in_ready_seen - seen, 0);
`else
        check("divzero_in_ready_cycles", in_ready_seen - seen, NW);
`endif
        // err must clear on the next accepted start.
        run_op(8'h05, 16'h0064, 1'b0, 0, 1'b1, 1'b0);

        // Abort in the calculation phase of the second word.
        rdy_mode = 0;
        push_expect(8'h10, 16'h5678, dz, r);
        start_op(8'h10, dz, r, 1'b0);
        feed(8'h56, ok);
        check("rst_in0_accepted", ok, 1);
        feed(8'h78, ok);
        check("rst_in1_accepted", ok, 1);
        repeat (3) begin @(posedge clk); #1; end
        check("busy_before_abort", bus.busy, 1);
        reset = 1'b1;
        #1;
        check_zero_outputs("abort");
        check("no_done_before_abort", d_exp.size(), 1);
        q_exp.delete();
        d_exp.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("idle_after_abort", bus.busy, 0);

        // Random operands, gaps and backpressure.
        for (int n = 0; n < 30; n++) begin
            rd = DW'($urandom_range(1, (1 << DW) - 1));
            ra = AW'($urandom);
            rg = 1'($urandom_range(0, 1));
            rm = $urandom_range(0, 2);
            run_op(rd, ra, rg, rm, (!rg && rm == 0), 1'($urandom_range(0, 1)));
        end

        repeat (3) begin @(posedge clk); #1; end
        check("q_queue_drained", q_exp.size(), 0);
        check("done_queue_drained", d_exp.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
